// File: rtl/band_mixer.sv
// band_mixer
//   Weighted mono mix of NUM_BANDS signed 16-bit band streams. Every band
//   has a capture register and a pending bit. Once all bands are pending,
//   the samples and gains are snapshotted. One shared multiply-accumulate
//   then walks the bands, one band per cycle. The sum is rounded and
//   saturated to 16 bits.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   band_data   NUM_BANDS x 16-bit signed samples, band i at [16*i +: 16]
//   band_valid  per-band one-cycle sample strobes
//   band_gain   NUM_BANDS x GAIN_WIDTH unsigned gains (Q1.(GAIN_WIDTH-1))
//   mix_out     signed mixed sample, held between results
//   mix_valid   one-cycle pulse when mix_out updates
//   mix_clip    high with mix_valid when the result saturated
//   overrun     sticky: a band delivered a new sample while still pending
//
// FSM states
//   state | meaning
//   IDLE  | waiting for every band to be pending; snapshot on entry to MAC
//   MAC   | one band product accumulated per cycle, idx 0..NUM_BANDS-1
//   OUT   | round, saturate and register the result, pulse mix_valid

module band_mixer #(
  parameter int NUM_BANDS  = 8,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_BANDS*16-1:0]          band_data,
  input  logic [NUM_BANDS-1:0]             band_valid,
  input  logic [NUM_BANDS*GAIN_WIDTH-1:0]  band_gain,
  output logic signed [15:0]               mix_out,
  output logic                             mix_valid,
  output logic                             mix_clip,
  output logic                             overrun
);

  localparam int IDXW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int PW   = 16 + GAIN_WIDTH + 1;
  localparam int ACCW = PW + IDXW;
  localparam int FRAC = GAIN_WIDTH - 1;

  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) <<< (FRAC - 1);
  localparam logic signed [ACCW-1:0] SMAX = ACCW'(32767);
  localparam logic signed [ACCW-1:0] SMIN = ACCW'(-32768);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  state_e                  state_q;
  logic [15:0]             cap_q  [NUM_BANDS];
  logic signed [15:0]      work_q [NUM_BANDS];
  logic [GAIN_WIDTH-1:0]   gain_q [NUM_BANDS];
  logic [NUM_BANDS-1:0]    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic signed [ACCW-1:0]  acc_q;
  logic [IDXW-1:0]         idx_q;
  logic signed [15:0]      mix_out_q;
  logic                    mix_valid_q, mix_clip_q;

  logic                    consume;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  acc_rnd, acc_shr;
  logic signed [15:0]      sat_val;
  logic                    sat_clip;

  // A strobe on the consuming edge belongs to the next mix. It sets pending
  // again and is not an overrun, because the old sample is taken on that
  // same edge.
  always_comb begin
    consume   = (state_q == IDLE) && (&pending_q);
    pending_d = (consume ? '0 : pending_q) | band_valid;
    overrun_d = overrun_q | (|(band_valid & pending_q & {NUM_BANDS{~consume}}));
  end

  // The gain is zero-extended to make it a non-negative signed operand.
  assign prod = PW'(work_q[idx_q]) * PW'($signed({1'b0, gain_q[idx_q]}));

  always_comb begin
    acc_rnd  = acc_q + HALF;
    acc_shr  = acc_rnd >>> FRAC;
    sat_val  = acc_shr[15:0];
    sat_clip = 1'b0;
    if (acc_shr > SMAX) begin
      sat_val  = 16'sh7fff;
      sat_clip = 1'b1;
    end else if (acc_shr < SMIN) begin
      sat_val  = -16'sh8000;
      sat_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      overrun_q   <= 1'b0;
      acc_q       <= '0;
      idx_q       <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      mix_clip_q  <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        cap_q[i]  <= '0;
        work_q[i] <= '0;
        gain_q[i] <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      mix_valid_q <= 1'b0;
      mix_clip_q  <= 1'b0;

      for (int i = 0; i < NUM_BANDS; i++) begin
        if (band_valid[i]) cap_q[i] <= band_data[16*i +: 16];
      end

      case (state_q)
        IDLE: begin
          if (consume) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
              work_q[i] <= $signed(cap_q[i]);
              gain_q[i] <= band_gain[GAIN_WIDTH*i +: GAIN_WIDTH];
            end
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q + ACCW'(prod);
          idx_q <= idx_q + IDXW'(1);
          if (idx_q == IDXW'(NUM_BANDS - 1)) state_q <= OUT;
        end
        OUT: begin
          mix_out_q   <= sat_val;
          mix_clip_q  <= sat_clip;
          mix_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign mix_clip  = mix_clip_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/band_mixer.md
# band_mixer

Sums the per-band sample streams produced by the band playback stages into one mono 16-bit output. Each band is weighted by its own gain, using a time-multiplexed single multiply-accumulate, and the result is saturated. It sits directly downstream of the NUM_BANDS playback instances, all clocked at 4.4 MHz and strobed at 44 kHz. Its output feeds the audio output / DAC path.

## Interface
- NUM_BANDS, 8, number of band inputs.
- GAIN_WIDTH, 8, unsigned gain width; gain is Q1.7 (128 = 1.0, 255 ≈ 1.992).
- clk  input  1  system clock (4.4 MHz).
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- band_data  input  NUM_BANDS*16  signed samples; band i occupies bits [16*i +: 16].
- band_valid  input  NUM_BANDS  one-cycle strobes; bit i qualifies band i.
- band_gain  input  NUM_BANDS*GAIN_WIDTH  unsigned gains; band i occupies [GAIN_WIDTH*i +: GAIN_WIDTH].
- mix_out  output  16  signed mixed sample; holds its value between results.
- mix_valid  output  1  one-cycle pulse when mix_out updates.
- mix_clip  output  1  high together with mix_valid when that result saturated; 0 otherwise.
- overrun  output  1  sticky; set when a band delivers a second sample before the mix consumed the first; cleared only by reset.

## Operation
- Capture
  - Per band: a 16-bit capture register and a pending bit.
  - When band_valid[i] is high, band_data[i] is latched and pending[i] is set.
  - If pending[i] is already set, the new sample overwrites the old one and overrun is set.
- FSM states: IDLE, MAC, OUT.
- IDLE
  - When all pending bits are 1:
    - copy the capture registers to working registers;
    - snapshot band_gain into gain registers;
    - set acc = 0 and idx = 0;
    - go to MAC.
  - pending is cleared on that edge. A band whose band_valid is high on the same edge keeps pending set and its new sample in the capture register; that sample goes into the next mix.
- MAC
  - Each cycle: acc += work[idx] * signed({1'b0, gain[idx]}).
  - The product is 16 × 9 signed, giving 25 bits.
  - acc is 25 + clog2(NUM_BANDS) bits, so it cannot overflow.
  - idx increments each cycle. On idx == NUM_BANDS-1 the final product is added and the FSM goes to OUT.
- OUT
  - r = (acc + 64) >>> 7 (arithmetic shift, round-half-up).
  - mix_out = r clamped to [-32768, 32767]; mix_clip = 1 if clamping occurred.
  - mix_valid = 1 for this one edge; return to IDLE.
- Gain changes after the snapshot have no effect on the mix in progress.
- Capture continues during MAC and OUT, independent of FSM state.
- Reset values
  - mix_out = 0, mix_valid = 0, mix_clip = 0, overrun = 0.
  - All pending bits 0; FSM = IDLE; acc and idx = 0.
- Reset asserted mid-MAC or mid-OUT aborts the mix. No mix_valid is produced and partial captures are discarded.

## Timing
- All band_valid high in cycle 0 → pending set in cycle 1 → MAC in cycles 2..NUM_BANDS+1 → OUT in cycle NUM_BANDS+2 → mix_valid high in cycle NUM_BANDS+3 (cycle 11 for 8 bands).
- Staggered valids: latency is measured from the last band's valid, with the same NUM_BANDS+3 cycles.
- Busy time is NUM_BANDS+3 cycles per mix, far below the 100-cycle sample period. No back-pressure exists to the playback stages.
- mix_valid is never high on two consecutive cycles.
- mix_clip is meaningful only while mix_valid is high.

## Test plan
- Unity path: all gains 128, band0 = 1000, others 0, all valids in cycle 0 → mix_out = 1000 and mix_valid = 1 in cycle 11, mix_clip = 0.
- Sum and positive saturation:
  - all gains 128, all bands 4000 → mix_out = 32000, mix_clip = 0;
  - all bands 5000 → mix_out = 32767, mix_clip = 1.
- Negative saturation and max gain: all bands −32768, all gains 255 → mix_out = −32768, mix_clip = 1.
- Rounding: gain0 = 64, others 0:
  - band0 = 1 → 1;
  - band0 = −1 → 0;
  - band0 = 3 → 2.
- Staggered arrival and overrun:
  - bands 0..7 arrive on cycles 0..7 at gain 128, with band3 strobed twice (100 then 200) before band7;
  - required: exactly one mix_valid, in cycle 7+11 = 18;
  - the sum uses 200 for band3;
  - overrun = 1 and stays set.
- Reset mid-MAC: drop rst_n during cycle 5 of a mix.
  - Required: no mix_valid; all outputs return to 0.
  - After release, a fresh full set of valids yields the correct result with standard latency.
